// File: rtl/fcs_xor_sequencer_if.sv
// fcs_xor_sequencer_if: frame start, payload bit source, CRC block link and serial output bundle.
interface fcs_xor_sequencer_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             bit_req;
    logic             bit_in;
    logic             crc_enable;
    logic             crc_s_in;
    logic [31:0]      crc_val;
    logic             out_bit;
    logic             out_valid;
    logic             out_is_fcs;
    logic             busy;
    logic             done;

    modport master (
        output start, len, bit_in, crc_val,
        input  bit_req, crc_enable, crc_s_in, out_bit, out_valid, out_is_fcs, busy, done
    );

    modport slave (
        input  start, len, bit_in, crc_val,
        output bit_req, crc_enable, crc_s_in, out_bit, out_valid, out_is_fcs, busy, done
    );
endinterface

// File: rtl/fcs_xor_sequencer.sv
// fcs_xor_sequencer: streams len payload bits through fcs_for_xor, then appends its 32-bit correction value.
module fcs_xor_sequencer #(
    parameter int LEN_W         = 16,
    parameter bit FCS_MSB_FIRST = 1'b1
) (
    input logic               clk,
    input logic               rst,
    fcs_xor_sequencer_if.slave bus
);
    localparam int CNT_W = (LEN_W < 6) ? 6 : LEN_W;

    typedef enum logic [2:0] {IDLE, PAYLOAD, LATCH, FCS, DONE} state_t;

    state_t           st, nxt;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [31:0]      sr, sr_d;
    logic             pay, fcs;

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= IDLE;
            cnt <= '0;
            sr  <= '0;
        end else begin
            st  <= nxt;
            cnt <= cnt_d;
            sr  <= sr_d;
        end
    end

    always_comb begin
        nxt   = st;
        cnt_d = cnt;
        sr_d  = sr;
        case (st)
            IDLE: if (bus.start) begin
                cnt_d = CNT_W'(bus.len);
                nxt   = (|bus.len) ? PAYLOAD : LATCH;
            end
            PAYLOAD: begin
                cnt_d = cnt - 1'b1;
                nxt   = (cnt == CNT_W'(1)) ? LATCH : PAYLOAD;
            end
            // fcs_for_xor is cleared after this cycle, so sr keeps the only copy
            LATCH: begin
                sr_d  = bus.crc_val;
                cnt_d = CNT_W'(32);
                nxt   = FCS;
            end
            FCS: begin
                cnt_d = cnt - 1'b1;
                sr_d  = FCS_MSB_FIRST ? {sr[30:0], 1'b0} : {1'b0, sr[31:1]};
                nxt   = (cnt == CNT_W'(1)) ? DONE : FCS;
            end
            default: nxt = IDLE;
        endcase
    end

    // outputs are forced low while rst is asserted, whatever the current state
    assign pay            = (st == PAYLOAD) && !rst;
    assign fcs            = (st == FCS) && !rst;
    assign bus.bit_req    = pay;
    assign bus.crc_enable = pay;
    assign bus.crc_s_in   = pay & bus.bit_in;
    assign bus.out_bit    = pay ? bus.bit_in : (fcs & (FCS_MSB_FIRST ? sr[31] : sr[0]));
    assign bus.out_valid  = pay | fcs;
    assign bus.out_is_fcs = fcs;
    assign bus.busy       = (st != IDLE) && !rst;
    assign bus.done       = (st == DONE) && !rst;
endmodule

// File: tb/tb_fcs_xor_sequencer.sv
// tb_fcs_xor_sequencer: directed frames through MSB-first and LSB-first sequencers sharing one stimulus.
module tb_fcs_xor_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    logic [31:0] crc0, crc1, fcs0, fcs1;
    logic [63:0] pay;
    int          n_req, n_en, n_busy, n_done, done_cyc;

    fcs_xor_sequencer_if #(.LEN_W(16)) i0 ();
    fcs_xor_sequencer_if #(.LEN_W(16)) i1 ();

    fcs_xor_sequencer #(.LEN_W(16), .FCS_MSB_FIRST(1'b1)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
    fcs_xor_sequencer #(.LEN_W(16), .FCS_MSB_FIRST(1'b0)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));

    always #5 clk = ~clk;

    assign i1.start   = i0.start;
    assign i1.len     = i0.len;
    assign i1.bit_in  = i0.bit_in;
    assign i0.crc_val = crc0;
    assign i1.crc_val = crc1;

    // model of fcs_for_xor: zero-init CRC32 register, cleared whenever enable is low
    function automatic logic [31:0] step(input logic [31:0] c, input logic b);
        return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? 32'h04C11DB7 : 32'h0);
    endfunction

    always @(posedge clk) begin
        crc0 <= i0.crc_enable ? step(crc0, i0.crc_s_in) : 32'h0;
        crc1 <= i1.crc_enable ? step(crc1, i1.crc_s_in) : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs0();
        return 32'({i0.bit_req, i0.crc_enable, i0.crc_s_in, i0.out_bit, i0.out_valid, i0.out_is_fcs, i0.busy, i0.done});
    endfunction

    function automatic logic [31:0] outs1();
        return 32'({i1.bit_req, i1.crc_enable, i1.crc_s_in, i1.out_bit, i1.out_valid, i1.out_is_fcs, i1.busy, i1.done});
    endfunction

    // starts a frame in the current negedge slot; inj[c] raises start again in cycle c
    task automatic run(input int n, input logic [63:0] bits, input logic [63:0] inj);
        int k = 0;
        fcs0 = '0; fcs1 = '0; pay = '0;
        n_req = 0; n_en = 0; n_busy = 0; n_done = 0; done_cyc = -1;
        @(negedge clk);
        i0.start = 1'b1;
        i0.len   = 16'(n);
        for (int c = 1; c <= n + 40; c++) begin
            @(negedge clk);
            i0.start = inj[c];
            if (i0.bit_req) i0.bit_in = bits[k];
            #1;
            if (i0.bit_req) begin
                n_req++;
                pay[k] = i0.out_bit;
                k++;
            end
            n_en   += int'(i0.crc_enable);
            n_busy += int'(i0.busy);
            if (i0.out_is_fcs) fcs0 = {fcs0[30:0], i0.out_bit};
            if (i1.out_is_fcs) fcs1 = {i1.out_bit, fcs1[31:1]};
            if (i0.done) begin
                n_done++;
                done_cyc = c;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        i0.start = 1'b0;
        i0.len = '0;
        i0.bit_in = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outs0", outs0(), 32'h0);
        chk("reset_outs1", outs1(), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run(1, 64'h1, 64'h0);
        chk("len1_fcs_msb", fcs0, 32'h04C11DB7);
        chk("len1_fcs_lsb", fcs1, 32'h04C11DB7);
        chk("len1_payload", pay[31:0], 32'h1);
        chk("len1_req", 32'(n_req), 32'd1);
        chk("len1_done_cyc", 32'(done_cyc), 32'd35);

        run(2, 64'h1, 64'h0);
        chk("len2_fcs_msb", fcs0, 32'h09823B6E);
        chk("len2_fcs_lsb", fcs1, 32'h09823B6E);
        chk("len2_crc_en", 32'(n_en), 32'd2);
        chk("len2_req", 32'(n_req), 32'd2);

        run(0, 64'h0, 64'h0);
        chk("len0_req", 32'(n_req), 32'd0);
        chk("len0_fcs_msb", fcs0, 32'h0);
        chk("len0_fcs_lsb", fcs1, 32'h0);
        chk("len0_busy", 32'(n_busy), 32'd34);
        chk("len0_done_cnt", 32'(n_done), 32'd1);
        chk("len0_done_cyc", 32'(done_cyc), 32'd34);

        run(8, 64'h0, 64'h0);
        chk("len8z_fcs_lsb", fcs1, 32'h0);
        chk("len8z_fcs_msb", fcs0, 32'h0);
        run(8, 64'h1, 64'h0);
        chk("len8_fcs_lsb", fcs1, 32'h690CE0EE);
        chk("len8_fcs_msb", fcs0, 32'h690CE0EE);

        @(negedge clk);
        i0.start  = 1'b1;
        i0.len    = 16'd20;
        i0.bit_in = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            i0.start = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_outs0", outs0(), 32'h0);
        chk("rst_mid_outs1", outs1(), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_after_outs0", outs0(), 32'h0);
        chk("rst_after_outs1", outs1(), 32'h0);
        run(1, 64'h1, 64'h0);
        chk("rst_new_fcs_msb", fcs0, 32'h04C11DB7);
        chk("rst_new_fcs_lsb", fcs1, 32'h04C11DB7);
        chk("rst_new_done_cyc", 32'(done_cyc), 32'd35);

        run(3, 64'h5, (64'h1 << 2) | (64'h1 << 10) | (64'h1 << 37));
        chk("inj_done_cnt", 32'(n_done), 32'd1);
        chk("inj_done_cyc", 32'(done_cyc), 32'd37);
        chk("inj_fcs_msb", fcs0, 32'h17C56B6B);
        chk("inj_payload", pay[31:0], 32'h5);
        @(negedge clk);
        i0.start = 1'b0;
        #1;
        chk("inj_idle_busy", 32'(i0.busy), 32'd0);

        run(2, 64'h1, 64'h0);
        run(1, 64'h1, 64'h0);
        chk("b2b_fcs_msb", fcs0, 32'h04C11DB7);
        chk("b2b_fcs_lsb", fcs1, 32'h04C11DB7);
        chk("b2b_done_cyc", 32'(done_cyc), 32'd35);

        @(negedge clk);
        i0.start = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/fcs_xor_sequencer.md
Name: fcs_xor_sequencer

Overview:
- Frame-level bit sequencer in front of fcs_for_xor.
- On start, pulls LEN tag-data bits from an upstream bit source at one bit per clk, forwards each bit to the output stream, and drives fcs_for_xor's enable/s_in.
- After the payload, captures fcs_for_xor's 32-bit XOR-difference value and appends it as 32 serial FCS-correction bits, so the modulated frame keeps a valid CRC32.

Parameters:
- LEN_W, 16: width of the payload bit-count input.
- FCS_MSB_FIRST, 1: 1 = emit crc_val[31] first (x^31 coefficient first, 802.11 order); 0 = emit crc_val[0] first.

Ports:
- clk  input  1  system clock; one payload/FCS bit per cycle.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle frame start request; sampled only in IDLE.
- len  input  LEN_W  payload length in bits; sampled with start.
- bit_req  output  1  high in every cycle a payload bit is consumed.
- bit_in  input  1  payload bit, valid in the same cycle as bit_req.
- crc_enable  output  1  to fcs_for_xor enable; low resets that block.
- crc_s_in  output  1  to fcs_for_xor s_in.
- crc_val  input  32  from fcs_for_xor val.
- out_bit  output  1  serial output bit (payload, then FCS correction).
- out_valid  output  1  out_bit is meaningful this cycle.
- out_is_fcs  output  1  out_bit is an FCS-correction bit.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last FCS bit.

Behaviour:
- Reset and outputs at reset:
  - rst has priority in any state, including mid-frame.
  - rst forces IDLE and clears the counter and shift register.
  - All outputs are 0 under reset. crc_enable=0 resets the CRC block as well.
- FSM states: IDLE, PAYLOAD, LATCH, FCS, DONE.
- IDLE:
  - start=1 loads cnt<=len.
  - Next state is PAYLOAD if len!=0, otherwise LATCH.
  - start is ignored in every state other than IDLE; no queuing.
- PAYLOAD:
  - bit_req=1, crc_enable=1, crc_s_in=bit_in, out_bit=bit_in, out_valid=1, out_is_fcs=0. These are combinational from state and bit_in.
  - cnt decrements each cycle. On the cycle with cnt==1, next state is LATCH.
  - Exactly len payload cycles; bit_in is never stalled.
- LATCH (1 cycle):
  - crc_enable=0, out_valid=0.
  - crc_val now reflects exactly len bits; sr<=crc_val.
  - fcs_for_xor resets at the end of this cycle; the captured copy in sr is authoritative.
  - cnt<=32; next state is FCS.
- FCS (32 cycles):
  - out_valid=1, out_is_fcs=1, crc_enable=0.
  - out_bit=sr[31] with left shift when FCS_MSB_FIRST=1; otherwise out_bit=sr[0] with right shift.
  - At cnt==1, next state is DONE.
- DONE (1 cycle): done=1, busy=1, then IDLE. A start arriving in DONE is ignored.
- busy=1 from the cycle after an accepted start through DONE.
- len=0: no PAYLOAD cycles. crc_val is 0 in LATCH (both CRC states equal init), so 32 zero FCS bits are sent.
- Latency:
  - start to first out_valid: 1 cycle.
  - Total frame occupancy: len+34 cycles after start (payload, LATCH, 32 FCS, DONE).
- Maximum len is 2^LEN_W-1; there is no wrap. cnt is LEN_W bits wide, with a minimum of 6 bits to hold 32.

Test Plan:
- start, len=1, bit_in=1 -> 1 payload cycle with out_bit=1. FCS bits equal 0x04C11DB7 MSB-first (0000_0100_1100_0001_0001_1101_1011_0111). done pulses at cycle 35 after start.
- len=2, bits 1,0 -> FCS value 0x09823B6E. Also check crc_enable is high exactly 2 cycles and bit_req is high exactly 2 cycles.
- len=0 -> no bit_req, 32 FCS bits all 0, busy for 34 cycles, done once.
- len=8, all zeros, FCS_MSB_FIRST=0 -> FCS all 0. Repeat with bits 1,0,0,0,0,0,0,0 and check output order is LSB-first of 0x04C11DB7<<7 (CRC-reduced, compared against a golden model).
- rst asserted in the 5th payload cycle of a len=20 frame -> next cycle IDLE, all outputs 0. A new start for len=1 (bit 1) then yields 0x04C11DB7, proving no stale CRC or counter state.
- start pulsed during PAYLOAD, FCS and DONE -> ignored, exactly one frame and one done pulse. Back-to-back start in the cycle after done is accepted.
